// File: rtl/adc_sample_byte_packer_pkg.sv
// Shared definitions for the ADC sample byte packer: sample field
// positions, byte marker constants, FSM state encodings and the
// sample-to-byte encoding helpers.
package adc_sample_byte_packer_pkg;

  localparam int unsigned SAMPLE_BITS = 12;
  localparam int unsigned P_BIT       = 11;
  localparam int unsigned OR_BIT      = 10;
  localparam int unsigned D_MSB       = 9;
  localparam int unsigned D_LSB       = 0;

  // Top three bits of every high byte; a low byte always has bit 7 clear,
  // so the consumer can resynchronise on the marker.
  localparam logic [2:0] HI_MARK = 3'b100;
  localparam logic       LO_MARK = 1'b0;

  typedef enum logic [1:0] {
    F_IDLE  = 2'd0,
    F_FETCH = 2'd1,
    F_CAPT  = 2'd2
  } fetch_state_t;

  typedef enum logic [1:0] {
    B_EMPTY = 2'd0,
    B_HI    = 2'd1,
    B_LO    = 2'd2
  } byte_state_t;

  // High byte: {1, 0, 0, P, OR, D[9:7]}
  function automatic logic [7:0] hi_byte(input logic [SAMPLE_BITS-1:0] s);
    return {HI_MARK, s[P_BIT], s[OR_BIT], s[D_MSB:D_MSB-2]};
  endfunction

  // Low byte: {0, D[6:0]}
  function automatic logic [7:0] lo_byte(input logic [SAMPLE_BITS-1:0] s);
    return {LO_MARK, s[D_MSB-3:D_LSB]};
  endfunction

endpackage

// File: rtl/adc_sample_byte_packer_prefetch.sv
// One-deep sample prefetch register for the ADC byte packer.
// Runs the fetch FSM against the upstream sample FIFO and holds one
// captured word (pf_word/pf_valid) until the byte FSM takes it.
module adc_sample_byte_packer_prefetch
  import adc_sample_byte_packer_pkg::*;
#(
  parameter int SAMPLE_W = 12
) (
  input  logic                ftdi_clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                sample_empty,
  input  logic [SAMPLE_W-1:0] sample_data,
  output logic                sample_rd_en,
  output logic [SAMPLE_W-1:0] pf_word,
  output logic                pf_valid,
  input  logic                pf_take
);

  fetch_state_t state;

  // Fetch FSM: issue one read when the prefetch slot is free, capture the
  // word on the following cycle; a flush abandons any read in flight.
  always_ff @(posedge ftdi_clk or posedge reset) begin
    if (reset) begin
      state        <= F_IDLE;
      sample_rd_en <= 1'b0;
      pf_valid     <= 1'b0;
    end else if (flush) begin
      state        <= F_IDLE;
      sample_rd_en <= 1'b0;
      pf_valid     <= 1'b0;
    end else begin
      case (state)
        F_IDLE: begin
          if (pf_take) begin
            pf_valid <= 1'b0;
          end
          if (!pf_valid && !sample_empty) begin
            state        <= F_FETCH;
            sample_rd_en <= 1'b1;
          end
        end
        F_FETCH: begin
          state        <= F_CAPT;
          sample_rd_en <= 1'b0;
        end
        F_CAPT: begin
          state    <= F_IDLE;
          pf_valid <= 1'b1;
        end
        default: begin
          state        <= F_IDLE;
          sample_rd_en <= 1'b0;
        end
      endcase
    end
  end

  // Prefetch data word: loaded from the FIFO output in the capture cycle;
  // qualified by pf_valid, so it needs no reset.
  always_ff @(posedge ftdi_clk) begin
    if (!flush && state == F_CAPT) begin
      pf_word <= sample_data;
    end
  end

endmodule

// File: rtl/adc_sample_byte_packer.sv
// ADC sample byte packer: turns 12-bit {P, OR, D[9:0]} samples from the
// capture FIFO into a high/low byte stream for the register interface.
// Optional feature macro: PACKER_SAMPLE_COUNT_EN adds the sample_count
// output and count_clr input (saturating count of fully emitted samples).
module adc_sample_byte_packer
  import adc_sample_byte_packer_pkg::*;
#(
  parameter int SAMPLE_W = 12
) (
  input  logic                ftdi_clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                sample_empty,
  input  logic [SAMPLE_W-1:0] sample_data,
  output logic                sample_rd_en,
  output logic                byte_empty,
  output logic [7:0]          byte_data,
  input  logic                byte_rd_en,
`ifdef PACKER_SAMPLE_COUNT_EN
  output logic [31:0]         sample_count,
  input  logic                count_clr,
`endif
  output logic                underflow
);

  byte_state_t         state;
  logic [SAMPLE_W-1:0] cur;
  logic [SAMPLE_W-1:0] pf_word;
  logic                pf_valid;
  logic                pf_take;
  logic                lo_accept;

  adc_sample_byte_packer_prefetch #(
    .SAMPLE_W(SAMPLE_W)
  ) u_sample_prefetch_reg (
    .ftdi_clk    (ftdi_clk),
    .reset       (reset),
    .flush       (flush),
    .sample_empty(sample_empty),
    .sample_data (sample_data),
    .sample_rd_en(sample_rd_en),
    .pf_word     (pf_word),
    .pf_valid    (pf_valid),
    .pf_take     (pf_take)
  );

  assign byte_empty = (state == B_EMPTY);
  assign lo_accept  = (state == B_LO) && byte_rd_en;

  // Take the prefetched word when idle, or on the low-byte read so the
  // next sample's high byte follows without a gap.
  always_comb begin
    pf_take = 1'b0;
    if (!flush && pf_valid) begin
      pf_take = (state == B_EMPTY) || lo_accept;
    end
  end

  // Byte FSM: emit high then low byte of the current sample, flag reads
  // made with nothing available.
  always_ff @(posedge ftdi_clk or posedge reset) begin
    if (reset) begin
      state     <= B_EMPTY;
      byte_data <= 8'h00;
      underflow <= 1'b0;
    end else if (flush) begin
      state     <= B_EMPTY;
      underflow <= 1'b0;
    end else begin
      case (state)
        B_EMPTY: begin
          if (byte_rd_en) begin
            underflow <= 1'b1;
          end
          if (pf_valid) begin
            state <= B_HI;
          end
        end
        B_HI: begin
          if (byte_rd_en) begin
            byte_data <= hi_byte(cur);
            state     <= B_LO;
          end
        end
        B_LO: begin
          if (byte_rd_en) begin
            byte_data <= lo_byte(cur);
            state     <= pf_valid ? B_HI : B_EMPTY;
          end
        end
        default: begin
          state <= B_EMPTY;
        end
      endcase
    end
  end

  // Current sample word: loaded from the prefetch slot on each take;
  // qualified by the byte FSM state, so it needs no reset.
  always_ff @(posedge ftdi_clk) begin
    if (pf_take) begin
      cur <= pf_word;
    end
  end

`ifdef PACKER_SAMPLE_COUNT_EN
  // Saturating count of samples whose low byte has been read.
  always_ff @(posedge ftdi_clk or posedge reset) begin
    if (reset) begin
      sample_count <= 32'd0;
    end else if (flush || count_clr) begin
      sample_count <= 32'd0;
    end else if (lo_accept && sample_count != 32'hFFFF_FFFF) begin
      sample_count <= sample_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_adc_sample_byte_packer.sv
// Self-checking bench for adc_sample_byte_packer: directed steps with
// random sample words, checked against a queue-based byte model.
module tb_adc_sample_byte_packer;

  logic        ftdi_clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        sample_empty;
  logic [11:0] sample_data;
  logic        sample_rd_en;
  logic        byte_empty;
  logic [7:0]  byte_data;
  logic        byte_rd_en;
  logic        underflow;
`ifdef PACKER_SAMPLE_COUNT_EN
  logic [31:0] sample_count;
  logic        count_clr;
`endif

  int errs   = 0;
  int checks = 0;

  logic [11:0] fifo_q[$];
  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];

  always #5 ftdi_clk = ~ftdi_clk;

  adc_sample_byte_packer #(.SAMPLE_W(12)) dut (
    .ftdi_clk    (ftdi_clk),
    .reset       (reset),
    .flush       (flush),
    .sample_empty(sample_empty),
    .sample_data (sample_data),
    .sample_rd_en(sample_rd_en),
    .byte_empty  (byte_empty),
    .byte_data   (byte_data),
    .byte_rd_en  (byte_rd_en),
`ifdef PACKER_SAMPLE_COUNT_EN
    .sample_count(sample_count),
    .count_clr   (count_clr),
`endif
    .underflow   (underflow)
  );

  // Upstream FIFO model: data appears the cycle after the read strobe.
  always @(negedge ftdi_clk) begin
    if (sample_rd_en && !reset && fifo_q.size() > 0) begin
      sample_data  = fifo_q.pop_front();
      sample_empty = (fifo_q.size() == 0);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference encoding from the byte format rules, using plain arithmetic.
  function automatic logic [7:0] ref_hi(input logic [11:0] s);
    return 8'h80 | 8'(s >> 7);
  endfunction
  function automatic logic [7:0] ref_lo(input logic [11:0] s);
    return 8'(s & 12'h07F);
  endfunction

  task automatic push_sample(input logic [11:0] s);
    fifo_q.push_back(s);
    sample_empty = 1'b0;
    exp_q.push_back(ref_hi(s));
    exp_q.push_back(ref_lo(s));
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge ftdi_clk);
  endtask

  // Single strobe; returns the byte presented the cycle after.
  task automatic read_byte(output logic [7:0] b);
    byte_rd_en = 1'b1;
    @(negedge ftdi_clk);
    byte_rd_en = 1'b0;
    b = byte_data;
  endtask

  // Consumer that strobes whenever a byte is available; bounded wait.
  task automatic stream_bytes(input string tag, input int n);
    int  got;
    int  cyc;
    logic strobed;
    got = 0;
    cyc = 0;
    got_q.delete();
    while (got < n && cyc < 300) begin
      byte_rd_en = !byte_empty;
      strobed    = byte_rd_en;
      @(negedge ftdi_clk);
      cyc++;
      if (strobed) begin
        got_q.push_back(byte_data);
        got++;
      end
    end
    byte_rd_en = 1'b0;
    check({tag, "_count"}, got, n);
    for (int i = 0; i < got; i++) begin
      logic [7:0] e;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
      check($sformatf("%s_byte%0d", tag, i), {24'd0, got_q[i]}, {24'd0, e});
    end
  endtask

  initial begin
    logic [7:0]  b;
    logic [11:0] s0, s1, s2;

    reset        = 1'b1;
    flush        = 1'b0;
    sample_empty = 1'b1;
    sample_data  = 12'h000;
    byte_rd_en   = 1'b0;
`ifdef PACKER_SAMPLE_COUNT_EN
    count_clr    = 1'b0;
`endif
    wait_cycles(3);
    check("rst_byte_empty", {31'd0, byte_empty}, 32'd1);
    check("rst_rd_en", {31'd0, sample_rd_en}, 32'd0);
    check("rst_byte_data", {24'd0, byte_data}, 32'd0);
    check("rst_underflow", {31'd0, underflow}, 32'd0);
`ifdef PACKER_SAMPLE_COUNT_EN
    check("rst_count", sample_count, 32'd0);
`endif
    reset = 1'b0;
    wait_cycles(2);

    // Sample {P=1, OR=0, D=2A5}: first-sample timing and byte values.
    push_sample(12'hAA5);
    @(negedge ftdi_clk);
    check("t1_rd_en_c1", {31'd0, sample_rd_en}, 32'd1);
    @(negedge ftdi_clk);
    check("t1_rd_en_c2", {31'd0, sample_rd_en}, 32'd0);
    @(negedge ftdi_clk);
    check("t1_empty_c3", {31'd0, byte_empty}, 32'd1);
    @(negedge ftdi_clk);
    check("t1_empty_c4", {31'd0, byte_empty}, 32'd0);
    read_byte(b);
    check("t1_hi", {24'd0, b}, 32'h95);
    read_byte(b);
    check("t1_lo", {24'd0, b}, 32'h25);
    check("t1_empty_after", {31'd0, byte_empty}, 32'd1);
    void'(exp_q.pop_front());
    void'(exp_q.pop_front());

    // Sample {P=0, OR=1, D=3FF}.
    push_sample(12'h7FF);
    stream_bytes("t2", 2);
    check("t2_hi_const", {24'd0, got_q.size() > 0 ? got_q[0] : 8'h00}, 32'h8F);
    check("t2_lo_const", {24'd0, byte_data}, 32'h7F);
`ifdef PACKER_SAMPLE_COUNT_EN
    check("t2_count", sample_count, 32'd2);
`endif

    // Read with nothing available: underflow set, data held; flush clears.
    byte_rd_en = 1'b1;
    @(negedge ftdi_clk);
    byte_rd_en = 1'b0;
    check("t3_underflow", {31'd0, underflow}, 32'd1);
    check("t3_data_hold", {24'd0, byte_data}, 32'h7F);
    check("t3_still_empty", {31'd0, byte_empty}, 32'd1);
    flush = 1'b1;
    @(negedge ftdi_clk);
    flush = 1'b0;
    check("t3_flush_uf", {31'd0, underflow}, 32'd0);
`ifdef PACKER_SAMPLE_COUNT_EN
    check("t3_flush_count", sample_count, 32'd0);
`endif

    // Four random queued samples streamed out in order.
    for (int i = 0; i < 4; i++) push_sample(12'($urandom_range(0, 4095)));
    stream_bytes("t4", 8);
    check("t4_underflow", {31'd0, underflow}, 32'd0);
`ifdef PACKER_SAMPLE_COUNT_EN
    check("t4_count", sample_count, 32'd4);
    count_clr = 1'b1;
    @(negedge ftdi_clk);
    count_clr = 1'b0;
    check("t4_count_clr", sample_count, 32'd0);
`endif

    // Two samples held (current + prefetch): four back-to-back reads, no gap.
    s0 = 12'($urandom_range(0, 4095));
    s1 = 12'($urandom_range(0, 4095));
    push_sample(s0);
    push_sample(s1);
    exp_q.delete();
    wait_cycles(12);
    byte_rd_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge ftdi_clk);
      case (i)
        0: check("t5_b0", {24'd0, byte_data}, {24'd0, ref_hi(s0)});
        1: check("t5_b1", {24'd0, byte_data}, {24'd0, ref_lo(s0)});
        2: check("t5_b2", {24'd0, byte_data}, {24'd0, ref_hi(s1)});
        default: check("t5_b3", {24'd0, byte_data}, {24'd0, ref_lo(s1)});
      endcase
      if (i < 3) check($sformatf("t5_nogap%0d", i), {31'd0, byte_empty}, 32'd0);
    end
    byte_rd_en = 1'b0;
    check("t5_empty_end", {31'd0, byte_empty}, 32'd1);
    check("t5_underflow", {31'd0, underflow}, 32'd0);

    // Flush in B_LO with a prefetch held: held sample lost, next starts high.
    s0 = 12'($urandom_range(0, 4095));
    s1 = 12'($urandom_range(0, 4095));
    s2 = 12'($urandom_range(0, 4095));
    fifo_q.push_back(s0);
    fifo_q.push_back(s1);
    fifo_q.push_back(s2);
    sample_empty = 1'b0;
    wait_cycles(12);
    read_byte(b);
    check("t6_hi0", {24'd0, b}, {24'd0, ref_hi(s0)});
    flush = 1'b1;
    @(negedge ftdi_clk);
    flush = 1'b0;
    check("t6_empty_after_flush", {31'd0, byte_empty}, 32'd1);
    exp_q.delete();
    exp_q.push_back(ref_hi(s2));
    exp_q.push_back(ref_lo(s2));
    stream_bytes("t6", 2);

    // Reset asserted while capturing: outputs return to reset values at once.
    s0 = 12'($urandom_range(0, 4095));
    fifo_q.push_back(s0);
    sample_empty = 1'b0;
    wait_cycles(2);
    reset = 1'b1;
    #1;
    check("t7_rd_en", {31'd0, sample_rd_en}, 32'd0);
    check("t7_byte_empty", {31'd0, byte_empty}, 32'd1);
    check("t7_byte_data", {24'd0, byte_data}, 32'd0);
    check("t7_underflow", {31'd0, underflow}, 32'd0);
    @(negedge ftdi_clk);
    reset = 1'b0;
    fifo_q.delete();
    sample_empty = 1'b1;
    exp_q.delete();
    @(negedge ftdi_clk);
    push_sample(12'($urandom_range(0, 4095)));
    stream_bytes("t7_resume", 2);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
